// File: rtl/mem_lsu_if.sv
// Word-wide data memory bus between the load/store unit (master) and the data memory (slave).
// mem_pc carries the PC of the current access so a bus monitor can log writes.
interface mem_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_pc,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_pc,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: one CPU access at a time over a req/ack word bus, with read-modify-write
// for sub-word stores, lane extraction/extension for sub-word loads, and a bus timeout.
module mem_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    mem_lsu_if.master   bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

    state_t      state_reg, state_next;
    logic [2:0]  op_reg;
    logic [1:0]  lane_reg;
    logic [15:0] wlow_reg;
    logic [31:0] pc_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;
    logic [15:0] cnt_reg;

    logic        misaligned;
    logic        is_load;
    logic [16:0] cnt_inc;
    logic        tmo_hit;
    logic [7:0]  rd_byte [4];
    logic [3:0]  lane_hit;
    logic [31:0] merged_word;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;

    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign is_load = (op_reg <= OP_LBU);
    assign cnt_inc = {1'b0, cnt_reg} + 17'd1;
    assign tmo_hit = (cnt_inc == TMO_LIMIT);

    // Per-lane view of the read word; sub-word stores overwrite only the selected lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi]  = bus.mem_rdata[8*gi +: 8];
            assign lane_hit[gi] = (op_reg == OP_SB) ? (lane_reg == 2'(gi))
                                                    : (lane_reg[1] == 1'(gi / 2));
            assign merged_word[8*gi +: 8] =
                !lane_hit[gi]       ? rd_byte[gi] :
                (op_reg == OP_SB)   ? wlow_reg[7:0] :
                                      wlow_reg[8*(gi % 2) +: 8];
        end
    endgenerate

    assign byte_val = rd_byte[lane_reg];
    assign half_val = lane_reg[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_val = bus.mem_rdata;
        case (op_reg)
            OP_LH:   load_val = {{16{half_val[15]}}, half_val};
            OP_LHU:  load_val = {16'h0000, half_val};
            OP_LB:   load_val = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  load_val = {24'h000000, byte_val};
            default: load_val = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (misaligned)       state_next = RESP;
                    else if (op == OP_SW) state_next = WR;
                    else                  state_next = RD;
                end
            end
            RD: begin
                if (bus.mem_ack)  state_next = is_load ? RESP : WR;
                else if (tmo_hit) state_next = RESP;
            end
            WR: begin
                if (bus.mem_ack || tmo_hit) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_reg != IDLE);
        done          = (state_reg == RESP);
        bus.mem_req   = (state_reg == RD) || (state_reg == WR);
        bus.mem_we    = (state_reg == WR);
        bus.mem_addr  = mem_addr_reg;
        bus.mem_wdata = mem_wdata_reg;
        bus.mem_pc    = pc_reg;
        rdata         = rdata_reg;
        err           = err_reg;
    end

    // Datapath; ack is only honoured in RD/WR, i.e. while mem_req is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_reg        <= OP_LW;
            lane_reg      <= 2'b00;
            wlow_reg      <= 16'h0000;
            pc_reg        <= 32'h0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            rdata_reg     <= 32'h0;
            err_reg       <= 1'b0;
            cnt_reg       <= 16'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        op_reg        <= op;
                        lane_reg      <= addr[1:0];
                        wlow_reg      <= wdata[15:0];
                        pc_reg        <= pc;
                        mem_addr_reg  <= {addr[31:2], 2'b00};
                        mem_wdata_reg <= wdata;
                        cnt_reg       <= 16'h0;
                        if (misaligned) err_reg <= 1'b1;
                    end
                end
                RD: begin
                    if (bus.mem_ack) begin
                        cnt_reg <= 16'h0;
                        if (is_load) begin
                            rdata_reg <= load_val;
                            err_reg   <= 1'b0;
                        end else begin
                            mem_wdata_reg <= merged_word;
                        end
                    end else if (tmo_hit) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= 32'h0;
                    end else begin
                        cnt_reg <= cnt_inc[15:0];
                    end
                end
                WR: begin
                    if (bus.mem_ack) begin
                        err_reg <= 1'b0;
                    end else if (tmo_hit) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= 32'h0;
                    end else begin
                        cnt_reg <= cnt_inc[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: word memory model with configurable ack delay, one task per scenario.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata;

    mem_lsu_if bus();

    mem_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata), .pc(pc),
        .busy(busy), .done(done), .rdata(rdata), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Memory model: 64 words, ack after ack_delay waiting cycles, or never.
    logic [31:0] mem [0:63];
    int          ack_delay = 0;
    bit          ack_never = 1'b0;
    int          wait_cnt = 0;
    int          writes = 0;
    bit          pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'h0;

    assign bus.mem_ack   = bus.mem_req && !ack_never && (wait_cnt >= ack_delay);
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) wait_cnt <= wait_cnt + 1;
        else                             wait_cnt <= 0;
        if (pre_en) mem[pre_idx] <= pre_val;
        if (bus.mem_req && bus.mem_we && bus.mem_ack) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            writes <= writes + 1;
            $display("%0d@%h: *%h <= %h", $time, bus.mem_pc, bus.mem_addr, bus.mem_wdata);
        end
    end

    // Observations of the last access, gathered by wait_done.
    int          cyc, reqcyc;
    bit          got_done, we_seen, unstable;
    logic [31:0] we_addr, we_data;

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] p);
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = wd; pc = p;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        logic [31:0] a0;
        bit first;
        cyc = 0; reqcyc = 0; got_done = 1'b0; we_seen = 1'b0; unstable = 1'b0;
        we_addr = 32'h0; we_data = 32'h0; a0 = 32'h0; first = 1'b1;
        repeat (max_cyc) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_req) begin
                reqcyc++;
                if (first) begin a0 = bus.mem_addr; first = 1'b0; end
                else if (bus.mem_addr !== a0) unstable = 1'b1;
            end
            if (bus.mem_req && bus.mem_we) begin
                if (we_seen && bus.mem_wdata !== we_data) unstable = 1'b1;
                we_seen = 1'b1; we_addr = bus.mem_addr; we_data = bus.mem_wdata;
            end
            if (done) begin got_done = 1'b1; break; end
        end
        $display("access op=%0d addr=%h done=%0b cyc=%0d req_cycles=%0d rdata=%h err=%0b",
                 op, addr, got_done, cyc, reqcyc, rdata, err);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
        total++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); else passed++;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
        total++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); else passed++;
        total++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0]  ops   [7] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3, 3'd4};
        logic [31:0] addrs [7] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h10, 32'h13};
        logic [31:0] exps  [7] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                                   32'h8899AABB, 32'hFFFFFFBB, 32'h00000088};
        preload(6'd4, 32'h8899AABB);
        preload(6'd5, 32'h11223344);
        ack_delay = 0; ack_never = 1'b0;
        for (int i = 0; i < 7; i++) begin
            start(ops[i], addrs[i], 32'h0, 32'h100 + 32'(i * 4));
            wait_done(10);
            total++; if (cyc !== 2 || !got_done) $display("FAIL load%0d_latency: got %0d want 2", i, cyc); else passed++;
            total++; if (rdata !== exps[i]) $display("FAIL load%0d_rdata: got %h want %h", i, rdata, exps[i]); else passed++;
            total++; if (err !== 1'b0) $display("FAIL load%0d_err: got %b want 0", i, err); else passed++;
        end
    endtask

    task automatic test_sub_store;
        start(3'd7, 32'h13, 32'h12345677, 32'h400);
        wait_done(10);
        total++; if (cyc !== 3 || !got_done) $display("FAIL sb_latency: got %0d want 3", cyc); else passed++;
        total++; if (we_seen !== 1'b1) $display("FAIL sb_write_phase: got %b want 1", we_seen); else passed++;
        total++; if (we_addr !== 32'h10) $display("FAIL sb_mem_addr: got %h want 00000010", we_addr); else passed++;
        total++; if (we_data !== 32'h7799AABB) $display("FAIL sb_mem_wdata: got %h want 7799aabb", we_data); else passed++;
        total++; if (mem[4] !== 32'h7799AABB) $display("FAIL sb_mem_word: got %h want 7799aabb", mem[4]); else passed++;
        total++; if (err !== 1'b0) $display("FAIL sb_err: got %b want 0", err); else passed++;
        start(3'd6, 32'h16, 32'hFFFFBEEF, 32'h404);
        wait_done(10);
        total++; if (cyc !== 3 || !got_done) $display("FAIL sh_latency: got %0d want 3", cyc); else passed++;
        total++; if (mem[5] !== 32'hBEEF3344) $display("FAIL sh_mem_word: got %h want beef3344", mem[5]); else passed++;
    endtask

    task automatic test_back_to_back;
        ack_delay = 3;
        start(3'd5, 32'h20, 32'hDEADBEEF, 32'h408);
        wait_done(20);
        total++; if (reqcyc !== 4) $display("FAIL sw_req_cycles: got %0d want 4", reqcyc); else passed++;
        total++; if (unstable !== 1'b0) $display("FAIL sw_bus_stable: got %b want 0", unstable); else passed++;
        total++; if (cyc !== 5 || !got_done) $display("FAIL sw_latency: got %0d want 5", cyc); else passed++;
        total++; if (mem[8] !== 32'hDEADBEEF) $display("FAIL sw_mem_word: got %h want deadbeef", mem[8]); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL sw_idle_gap: got busy=%b done=%b want 0 0", busy, done); else passed++;
        ack_delay = 0;
        start(3'd0, 32'h20, 32'h0, 32'h40C);
        wait_done(10);
        total++; if (cyc !== 2 || !got_done) $display("FAIL lw_after_sw_latency: got %0d want 2", cyc); else passed++;
        total++; if (rdata !== 32'hDEADBEEF) $display("FAIL lw_after_sw_rdata: got %h want deadbeef", rdata); else passed++;
    endtask

    task automatic test_misaligned;
        logic [2:0]  ops   [2] = '{3'd0, 3'd6};
        logic [31:0] addrs [2] = '{32'h22, 32'h23};
        for (int i = 0; i < 2; i++) begin
            start(ops[i], addrs[i], 32'h5555AAAA, 32'h410);
            wait_done(10);
            total++; if (cyc !== 1 || !got_done) $display("FAIL misal%0d_latency: got %0d want 1", i, cyc); else passed++;
            total++; if (err !== 1'b1) $display("FAIL misal%0d_err: got %b want 1", i, err); else passed++;
            total++; if (reqcyc !== 0) $display("FAIL misal%0d_bus: got %0d req cycles want 0", i, reqcyc); else passed++;
        end
        @(negedge clk);
        total++; if (err !== 1'b1) $display("FAIL misal_err_hold: got %b want 1", err); else passed++;
    endtask

    task automatic test_timeout;
        int w0;
        ack_never = 1'b1;
        start(3'd0, 32'h10, 32'h0, 32'h414);
        wait_done(20);
        total++; if (reqcyc !== 4) $display("FAIL tmo_lw_req_cycles: got %0d want 4", reqcyc); else passed++;
        total++; if (cyc !== 5 || !got_done) $display("FAIL tmo_lw_latency: got %0d want 5", cyc); else passed++;
        total++; if (err !== 1'b1) $display("FAIL tmo_lw_err: got %b want 1", err); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL tmo_lw_rdata: got %h want 0", rdata); else passed++;
        w0 = writes;
        start(3'd7, 32'h10, 32'h00000055, 32'h418);
        wait_done(20);
        total++; if (reqcyc !== 4) $display("FAIL tmo_sb_req_cycles: got %0d want 4", reqcyc); else passed++;
        total++; if (we_seen !== 1'b0) $display("FAIL tmo_sb_no_write: got %b want 0", we_seen); else passed++;
        total++; if (err !== 1'b1 || !got_done) $display("FAIL tmo_sb_err: got %b want 1", err); else passed++;
        total++; if (writes !== w0) $display("FAIL tmo_sb_writes: got %0d want %0d", writes, w0); else passed++;
        ack_never = 1'b0;
        start(3'd0, 32'h10, 32'h0, 32'h41C);
        wait_done(10);
        total++; if (rdata !== 32'h7799AABB) $display("FAIL post_tmo_rdata: got %h want 7799aabb", rdata); else passed++;
        total++; if (err !== 1'b0) $display("FAIL post_tmo_err: got %b want 0", err); else passed++;
    endtask

    task automatic test_reset_abort;
        int w0, spurious;
        ack_never = 1'b1;
        w0 = writes;
        start(3'd5, 32'h30, 32'h0BADF00D, 32'h420);
        @(negedge clk);
        total++; if (bus.mem_we !== 1'b1) $display("FAIL abort_in_wr: got mem_we=%b want 1", bus.mem_we); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.mem_req !== 1'b0) $display("FAIL abort_mem_req: got %b want 0", bus.mem_req); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL abort_rdata: got %h want 0", rdata); else passed++;
        reset = 1'b1;
        ack_never = 1'b0;
        spurious = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) spurious++;
        end
        total++; if (spurious !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", spurious); else passed++;
        total++; if (writes !== w0) $display("FAIL abort_no_write: got %0d want %0d", writes, w0); else passed++;
        start(3'd0, 32'h10, 32'h0, 32'h424);
        wait_done(10);
        total++; if (cyc !== 2 || !got_done) $display("FAIL post_reset_latency: got %0d want 2", cyc); else passed++;
        total++; if (rdata !== 32'h7799AABB) $display("FAIL post_reset_rdata: got %h want 7799aabb", rdata); else passed++;
        total++; if (err !== 1'b0) $display("FAIL post_reset_err: got %b want 0", err); else passed++;
    endtask

    initial begin
        test_reset;
        test_loads;
        test_sub_store;
        test_back_to_back;
        test_misaligned;
        test_timeout;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- CPU-side initiator for the word-wide data memory bus: the load/store unit that the M stage drives.
- Accepts one load/store per transaction and issues word-aligned read/write requests with a req/ack handshake.
- Performs read-modify-write for sub-word stores, and sign/zero-extension and lane extraction for sub-word loads.
- Stalls the pipeline via busy until the access completes.

Parameters:
- TIMEOUT, 255: max cycles mem_req may stay high without mem_ack before abort (1..65535).

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block
- req  in  1  CPU access request, sampled only in IDLE
- op  in  3  0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5 sw, 6 sh, 7 sb
- addr  in  32  byte address
- wdata  in  32  store data (low byte/half used for sb/sh)
- pc  in  32  PC of the instruction, for the write log
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- rdata  out  32  load result, valid while done=1
- err  out  1  valid with done: misalignment or timeout
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word, valid when mem_ack=1
- mem_ack  in  1  responder completion, may be asserted in the same cycle as mem_req

Behaviour:
- Reset: state IDLE; busy, done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_wdata, timeout counter = 0.
- Reset mid-transaction aborts it: mem_req low after that edge, and no done pulse is produced.
- States: IDLE, RD, WR, RESP.
- IDLE + req=1: latch op, addr, wdata, pc.
  - Alignment: lw/sw need addr[1:0]==0; lh/lhu/sh need addr[0]==0.
  - Misaligned: go to RESP with err=1 and no bus traffic.
  - Aligned loads and sb/sh: go to RD.
  - sw: go to WR with mem_wdata=wdata.
- RD: mem_req=1, mem_we=0.
  - On posedge with mem_ack=1 and a load: form rdata, go to RESP.
  - On posedge with mem_ack=1 and sb/sh: merge the store into mem_rdata, go to WR.
- WR: mem_req=1, mem_we=1. On posedge with mem_ack=1, go to RESP.
  - At that edge print "%d@%h: *%h <= %h" with $time, latched pc, mem_addr, mem_wdata.
- RESP: done=1 for exactly one cycle, then IDLE. req is not sampled in RESP, so back-to-back accesses have a minimum 1-cycle IDLE gap.
- Bus rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - mem_req deasserts the cycle after the ack edge. RD->WR keeps mem_req high with mem_we rising.
  - mem_ack while mem_req=0 is ignored.
- Lanes are little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half h = bits [16h+15:16h], h = addr[1].
- Loads:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - lw returns mem_rdata unchanged.
- Stores:
  - sb replaces only lane k with wdata[7:0].
  - sh replaces half h with wdata[15:0].
  - All other bits come from the RD word.
- Timeout:
  - The counter clears on entry to RD/WR and increments each cycle mem_req=1 without ack.
  - When it reaches TIMEOUT: drop mem_req, go to RESP with err=1, rdata=0.
  - A sub-word store that times out in RD issues no write.
- Latency with zero-wait ack (accept edge = cycle 0):
  - loads and sw: done in cycle 2;
  - sb/sh: done in cycle 3;
  - misaligned: done in cycle 1.
- rdata holds its value until the next load completes. err holds until the next done.

Test Plan:
- Memory word 0x10 = 0x8899AABB, zero-wait ack; lb addr 0x11 -> done at cycle 2, rdata=0xFFFFFFAA, err=0. lbu addr 0x11 -> 0x000000AA. lh 0x12 -> 0xFFFF8899. lhu 0x12 -> 0x00008899.
- sb addr 0x13, wdata 0x12345677, word 0x10 = 0x8899AABB -> RD then WR; mem_wdata=0x7799AABB, mem_addr=0x10, done at cycle 3; log line shows pc and 0x7799aabb.
- sw addr 0x20 wdata 0xDEADBEEF, ack delayed 3 cycles -> mem_req high 4 cycles with stable addr/data; done 1 cycle after the ack edge; followed by lw 0x20 -> rdata 0xDEADBEEF.
- Misaligned lw addr 0x22 and sh addr 0x23 -> done next cycle, err=1, mem_req never asserted.
- TIMEOUT=4, ack never asserted on lw -> mem_req high exactly 4 cycles, then done with err=1, rdata=0. Same on sb -> no WR phase occurs.
- Reset driven to 0 while in WR with ack withheld -> next cycle mem_req=0, busy=0, no done. After reset returns to 1, a new lw completes normally.
